// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU op encodings, result-source
// selects, immediate formats and the registered control bundle.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  // funct7[5] selects SUB only for R-type; for I-type it only matters on SRAI
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                         input logic is_r);
    case (f3)
      3'b000:  alu_dec = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_regfile.sv
// Register file with async read, x0 hard-wired to zero and async clear.
// DECODE_WB_BYPASS_EN makes reads write-through from the writeback port.
module regfile #(
  parameter int XLEN    = 32,
  parameter int NREG_AW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [NREG_AW-1:0] wa,
  input  logic [XLEN-1:0]    wd,
  input  logic [NREG_AW-1:0] ra1,
  input  logic [NREG_AW-1:0] ra2,
  output logic [XLEN-1:0]    rd1,
  output logic [XLEN-1:0]    rd2
);
  localparam int NREG = 1 << NREG_AW;

  logic [NREG-1:0][XLEN-1:0] mem_q, mem_d;

  // entry 0 is never written, so it stays at its reset value of zero
  always_comb begin
    mem_d = mem_q;
    if (we && wa != '0) mem_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rd1 = (we && wa != '0 && wa == ra1) ? wd : mem_q[ra1];
  assign rd2 = (we && wa != '0 && wa == ra2) ? wd : mem_q[ra2];
`else
  assign rd1 = mem_q[ra1];
  assign rd2 = mem_q[ra2];
`endif

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode + ID/EX pipeline register with load-use stall detection.
// Optional write-through register reads: define DECODE_WB_BYPASS_EN.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREG_AW = 5,
  parameter int ALUC_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        InstrD,
  input  logic               ValidD,
  input  logic [XLEN-1:0]    PCD,
  input  logic [XLEN-1:0]    PCPlus4D,
  input  logic               RegWriteW,
  input  logic [NREG_AW-1:0] RDW,
  input  logic [XLEN-1:0]    ResultW,
  input  logic               StallE,
  input  logic               FlushE,
  output logic               StallD,
  output logic               ValidE,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               ALUSrcE,
  output logic               BranchE,
  output logic               JumpE,
  output logic [1:0]         ResultSrcE,
  output logic [ALUC_W-1:0]  ALUControlE,
  output logic [2:0]         Funct3E,
  output logic [XLEN-1:0]    RD1_E,
  output logic [XLEN-1:0]    RD2_E,
  output logic [XLEN-1:0]    Imm_ExtE,
  output logic [NREG_AW-1:0] RD_E,
  output logic [NREG_AW-1:0] Rs1_E,
  output logic [NREG_AW-1:0] Rs2_E,
  output logic [XLEN-1:0]    PCE,
  output logic [XLEN-1:0]    PCPlus4E
);

  typedef struct packed {
    logic               valid;
    ctrl_t              ctrl;
    logic [2:0]         funct3;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc4;
    logic [NREG_AW-1:0] rd;
    logic [NREG_AW-1:0] rs1;
    logic [NREG_AW-1:0] rs2;
  } idex_t;

  idex_t              idex_q, idex_d, dec;
  ctrl_t              ctrl;
  imm_src_e           imm_src;
  logic               legal, rs1_used, rs2_used, a_zero, a_pc, haz_lu;
  logic signed [31:0] imm32;
  logic [NREG_AW-1:0] rs1_a, rs2_a, rd_a;
  logic [XLEN-1:0]    rf_rd1, rf_rd2;
  logic [6:0]         opcode;

  assign opcode = InstrD[6:0];
  assign rs1_a  = NREG_AW'(InstrD[19:15]);
  assign rs2_a  = NREG_AW'(InstrD[24:20]);
  assign rd_a   = NREG_AW'(InstrD[11:7]);

  regfile #(.XLEN(XLEN), .NREG_AW(NREG_AW)) u_rf (
    .clk(clk), .rst_n(reset), .we(RegWriteW), .wa(RDW), .wd(ResultW),
    .ra1(rs1_a), .ra2(rs2_a), .rd1(rf_rd1), .rd2(rf_rd2)
  );

  always_comb begin
    ctrl     = '0;
    imm_src  = IMM_I;
    legal    = 1'b1;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    a_zero   = 1'b0;
    a_pc     = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.result_src = RES_MEM;
        rs1_used = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; imm_src = IMM_S;
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_dec(InstrD[14:12], InstrD[30], 1'b1);
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_I: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
        ctrl.alu_ctrl  = alu_dec(InstrD[14:12], InstrD[30], 1'b0);
        rs1_used = 1'b1;
      end
      OP_BR: begin
        ctrl.branch = 1'b1; ctrl.alu_ctrl = ALU_SUB; imm_src = IMM_B;
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.result_src = RES_PC4;
        imm_src = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.alu_src = 1'b1;
        ctrl.result_src = RES_PC4; rs1_used = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; imm_src = IMM_U; a_zero = 1'b1;
      end
      // EX has no separate operand-A select, so auipc carries the PC on RD1
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; imm_src = IMM_U; a_pc = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal || !ValidD) ctrl = '0;
  end

  always_comb begin
    case (imm_src)
      IMM_S:   imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                        InstrD[11:8], 1'b0};
      IMM_U:   imm32 = {InstrD[31:12], 12'b0};
      IMM_J:   imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                        InstrD[30:21], 1'b0};
      default: imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.valid  = ValidD & legal;
    dec.ctrl   = ctrl;
    dec.funct3 = InstrD[14:12];
    dec.rd1    = a_zero ? '0 : (a_pc ? PCD : rf_rd1);
    dec.rd2    = rf_rd2;
    dec.imm    = XLEN'(imm32);
    dec.pc     = PCD;
    dec.pc4    = PCPlus4D;
    dec.rd     = rd_a;
    dec.rs1    = rs1_a;
    dec.rs2    = rs2_a;
  end

  assign haz_lu = idex_q.valid && idex_q.ctrl.result_src == RES_MEM &&
                  idex_q.ctrl.reg_write && idex_q.rd != '0 && ValidD &&
                  ((rs1_used && idex_q.rd == rs1_a) || (rs2_used && idex_q.rd == rs2_a));

  // gated by reset so StallD falls as soon as reset asserts, even mid-stall
  assign StallD = reset & (haz_lu | StallE);

  always_comb begin
    idex_d = idex_q;
    if (FlushE)      idex_d = '0;
    else if (StallE) idex_d = idex_q;
    else if (haz_lu) idex_d = '0;
    else             idex_d = dec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign ValidE      = idex_q.valid;
  assign RegWriteE   = idex_q.ctrl.reg_write;
  assign MemWriteE   = idex_q.ctrl.mem_write;
  assign ALUSrcE     = idex_q.ctrl.alu_src;
  assign BranchE     = idex_q.ctrl.branch;
  assign JumpE       = idex_q.ctrl.jump;
  assign ResultSrcE  = idex_q.ctrl.result_src;
  assign ALUControlE = ALUC_W'(idex_q.ctrl.alu_ctrl);
  assign Funct3E     = idex_q.funct3;
  assign RD1_E       = idex_q.rd1;
  assign RD2_E       = idex_q.rd2;
  assign Imm_ExtE    = idex_q.imm;
  assign RD_E        = idex_q.rd;
  assign Rs1_E       = idex_q.rs1;
  assign Rs2_E       = idex_q.rs2;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc4;

endmodule
